uart_cmd_rx: RTL
================

Name: uart_cmd_rx

Overview:
- Serial receive path of the robot's debug UART, complementing the telemetry transmit path.
- Deserialises 8N1 bytes from the host terminal and parses CR-terminated two-character ASCII commands.
- Drives registered override outputs (direction, drive, manual-override enable) into the drive controller.
- Sits beside the telemetry UART on the same clk/rst domain and shares its baud setting.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (clk/baud); minimum 4.
- SYNC_STAGES, 2, flops in the rxData input synchroniser; minimum 2.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- rxData  input  1  serial line from host, idle high, asynchronous to clk
- rxByte  output  8  last correctly framed byte
- rxValid  output  1  one-cycle pulse, rxByte updated
- frameErr  output  1  one-cycle pulse, stop bit sampled low
- dirCmd  output  2  commanded direction, DC_* encoding from the shared parameters header
- driveCmd  output  1  commanded drive direction, FORWARDS/REVERSE encoding
- overrideEn  output  1  1 = downstream uses dirCmd/driveCmd instead of sensors
- cmdValid  output  1  one-cycle pulse, command accepted and outputs updated
- cmdError  output  1  one-cycle pulse, line rejected

Behaviour:
- Reset values: rxByte=0, rxValid=0, frameErr=0, dirCmd=DC_STOP, driveCmd=FORWARDS, overrideEn=0, cmdValid=0, cmdError=0, line buffer empty, both FSMs idle.
- Reset mid-frame or mid-line discards all partial state.
- rxData passes through SYNC_STAGES flops. All logic uses the synchronised bit rxS.
- Receiver FSM: R_IDLE, R_START, R_DATA, R_STOP, R_WAIT_IDLE. Bit counter width is $clog2(CLKS_PER_BIT).
  - R_IDLE: when rxS=0, clear counter and go to R_START.
  - R_START: after CLKS_PER_BIT/2 cycles, sample rxS. If 0, go to R_DATA with bit index 0. If 1 (glitch), return to R_IDLE with no pulse.
  - R_DATA: every CLKS_PER_BIT cycles, sample rxS into shift[index], LSB first. After index 7, go to R_STOP.
  - R_STOP: after CLKS_PER_BIT cycles, sample rxS.
    - If 1: the next cycle rxByte<=shift and rxValid=1 for exactly one cycle; go to R_IDLE.
    - If 0: frameErr=1 for one cycle; go to R_WAIT_IDLE.
  - R_WAIT_IDLE: stay until rxS=1, then go to R_IDLE. A break condition yields exactly one frameErr.
- Back-to-back frames with no idle gap must be received. Start detection is active in R_IDLE from the cycle after rxValid.
- Parser FSM: C_CMD, C_ARG, C_TERM, C_DISCARD. It acts only on cycles with rxValid=1 or frameErr=1.
  - LF (0x0A) is ignored in every state.
  - C_CMD: "D" or "F" or "M" is latched as the opcode, go to C_ARG. CR stays in C_CMD silently (empty line). Any other byte goes to C_DISCARD.
  - C_ARG: the argument is latched and the state goes to C_TERM if the pair is legal. Legal pairs:
    - D with P/L/R/S -> DC_PROCEED/DC_TURN_LEFT/DC_TURN_RIGHT/DC_STOP
    - F with F/R -> FORWARDS/REVERSE
    - M with 0/1 -> overrideEn
    - Illegal argument goes to C_DISCARD. CR here gives cmdError and returns to C_CMD.
  - C_TERM: CR applies the command: the target output is updated and cmdValid=1 in the cycle after the CR's rxValid, then C_CMD. Any other byte goes to C_DISCARD (no partial apply).
  - C_DISCARD: on CR, cmdError=1 in the cycle after the CR's rxValid, then C_CMD.
  - frameErr in any parser state forces C_DISCARD.
- Only the addressed output changes on cmdValid; the others hold. Commands are case-sensitive, uppercase only.
- cmdValid and cmdError are mutually exclusive.
- Latency from the stop-bit sample of CR to cmdValid is 2 clk.

Test Plan:
- CLKS_PER_BIT=16, send 0x55 then 0xA3 back-to-back -> rxValid twice, rxByte 0x55 then 0xA3, no frameErr.
- Send "DL\r\n" -> one cmdValid 2 clk after CR stop sample, dirCmd=DC_TURN_LEFT, driveCmd/overrideEn unchanged, LF produces nothing.
- Send "M1\r", "FR\r", "DS\r" -> overrideEn=1, driveCmd=REVERSE, dirCmd=DC_STOP, three cmdValid pulses.
- Send "DX\r", "DPP\r", "Q\r" -> three cmdError pulses, dirCmd stays DC_STOP, no cmdValid.
- Byte 0x44 with stop bit forced low, then "\r", then "DR\r" -> frameErr once, cmdError on first CR, then cmdValid with dirCmd=DC_TURN_RIGHT.
- 3-cycle low glitch on rxData -> no rxValid/frameErr. Assert rst mid-byte of "D" -> all outputs at reset values, next clean "FF\r" gives driveCmd=FORWARDS with cmdValid.

Source files
------------

// File: rtl/uart_cmd_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_rx_if
// Purpose  : Serial input and decoded byte/command outputs of the debug UART RX.
// Revision : 1.0
// ============================================================================
interface uart_cmd_rx_if;
    logic       rxData;
    logic [7:0] rxByte;
    logic       rxValid;
    logic       frameErr;
    logic [1:0] dirCmd;
    logic       driveCmd;
    logic       overrideEn;
    logic       cmdValid;
    logic       cmdError;

    modport master (
        input  rxData,
        output rxByte, rxValid, frameErr,
        output dirCmd, driveCmd, overrideEn, cmdValid, cmdError
    );

    modport slave (
        output rxData,
        input  rxByte, rxValid, frameErr,
        input  dirCmd, driveCmd, overrideEn, cmdValid, cmdError
    );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_rx
// Purpose  : 8N1 receiver plus CR-terminated two-character command parser that
//            drives the manual-override outputs of the drive controller.
// Revision : 1.0
// ============================================================================
module uart_cmd_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int SYNC_STAGES  = 2
) (
    input  logic           clk,
    input  logic           rst,
    uart_cmd_rx_if.master  bus
);

    localparam int              CW             = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   c_HALF_LAST    = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]   c_BIT_LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [1:0]      c_DC_STOP       = 2'd0;
    localparam logic [1:0]      c_DC_PROCEED    = 2'd1;
    localparam logic [1:0]      c_DC_TURN_LEFT  = 2'd2;
    localparam logic [1:0]      c_DC_TURN_RIGHT = 2'd3;
    localparam logic            c_FORWARDS     = 1'b0;
    localparam logic            c_REVERSE      = 1'b1;
    localparam logic [7:0]      c_CR           = 8'h0D;
    localparam logic [7:0]      c_LF           = 8'h0A;

    typedef enum logic [2:0] {
        R_IDLE      = 3'd0,
        R_START     = 3'd1,
        R_DATA      = 3'd2,
        R_STOP      = 3'd3,
        R_WAIT_IDLE = 3'd4
    } rxState_t;

    typedef enum logic [1:0] {
        C_CMD     = 2'd0,
        C_ARG     = 2'd1,
        C_TERM    = 2'd2,
        C_DISCARD = 2'd3
    } cState_t;

    typedef enum logic [1:0] {
        OP_D = 2'd0,
        OP_F = 2'd1,
        OP_M = 2'd2
    } op_t;

    // ---------------------------------------------------------------- sync
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rxS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= '1;
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], bus.rxData};
    end
    assign w_rxS = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------ receiver
    rxState_t   r_rxState, w_rxStateNxt;
    logic [CW-1:0] r_cnt, w_cntNxt;
    logic [2:0] r_idx, w_idxNxt;
    logic [7:0] r_shift, w_shiftNxt;
    logic [7:0] r_rxByte, w_rxByteNxt;
    logic       r_rxValid, w_rxValidNxt;
    logic       r_frameErr, w_frameErrNxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rxState  <= R_IDLE;
            r_cnt      <= '0;
            r_idx      <= 3'd0;
            r_shift    <= 8'd0;
            r_rxByte   <= 8'd0;
            r_rxValid  <= 1'b0;
            r_frameErr <= 1'b0;
        end else begin
            r_rxState  <= w_rxStateNxt;
            r_cnt      <= w_cntNxt;
            r_idx      <= w_idxNxt;
            r_shift    <= w_shiftNxt;
            r_rxByte   <= w_rxByteNxt;
            r_rxValid  <= w_rxValidNxt;
            r_frameErr <= w_frameErrNxt;
        end
    end

    always_comb begin
        w_rxStateNxt  = r_rxState;
        w_cntNxt      = r_cnt;
        w_idxNxt      = r_idx;
        w_shiftNxt    = r_shift;
        w_rxByteNxt   = r_rxByte;
        w_rxValidNxt  = 1'b0;
        w_frameErrNxt = 1'b0;
        unique case (r_rxState)
            R_IDLE: begin
                if (!w_rxS) begin
                    w_cntNxt     = '0;
                    w_rxStateNxt = R_START;
                end
            end
            R_START: begin
                // Mid-start-bit recheck rejects short glitches on the line.
                if (r_cnt == c_HALF_LAST) begin
                    w_cntNxt = '0;
                    if (!w_rxS) begin
                        w_idxNxt     = 3'd0;
                        w_rxStateNxt = R_DATA;
                    end else begin
                        w_rxStateNxt = R_IDLE;
                    end
                end else begin
                    w_cntNxt = r_cnt + CW'(1);
                end
            end
            R_DATA: begin
                if (r_cnt == c_BIT_LAST) begin
                    w_cntNxt          = '0;
                    w_shiftNxt[r_idx] = w_rxS;
                    if (r_idx == 3'd7) w_rxStateNxt = R_STOP;
                    else               w_idxNxt     = r_idx + 3'd1;
                end else begin
                    w_cntNxt = r_cnt + CW'(1);
                end
            end
            R_STOP: begin
                if (r_cnt == c_BIT_LAST) begin
                    w_cntNxt = '0;
                    if (w_rxS) begin
                        w_rxByteNxt  = r_shift;
                        w_rxValidNxt = 1'b1;
                        w_rxStateNxt = R_IDLE;
                    end else begin
                        w_frameErrNxt = 1'b1;
                        w_rxStateNxt  = R_WAIT_IDLE;
                    end
                end else begin
                    w_cntNxt = r_cnt + CW'(1);
                end
            end
            R_WAIT_IDLE: begin
                if (w_rxS) w_rxStateNxt = R_IDLE;
            end
            default: w_rxStateNxt = R_IDLE;
        endcase
    end

    // -------------------------------------------------------------- parser
    cState_t    r_cState, w_cStateNxt;
    op_t        r_op, w_opNxt;
    logic [1:0] r_arg, w_argNxt;
    logic [1:0] r_dir, w_dirNxt;
    logic       r_drive, w_driveNxt;
    logic       r_ovr, w_ovrNxt;
    logic       r_cmdValid, w_cmdValidNxt;
    logic       r_cmdError, w_cmdErrorNxt;
    logic       w_argLegal;
    logic [1:0] w_argDec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cState   <= C_CMD;
            r_op       <= OP_D;
            r_arg      <= 2'd0;
            r_dir      <= c_DC_STOP;
            r_drive    <= c_FORWARDS;
            r_ovr      <= 1'b0;
            r_cmdValid <= 1'b0;
            r_cmdError <= 1'b0;
        end else begin
            r_cState   <= w_cStateNxt;
            r_op       <= w_opNxt;
            r_arg      <= w_argNxt;
            r_dir      <= w_dirNxt;
            r_drive    <= w_driveNxt;
            r_ovr      <= w_ovrNxt;
            r_cmdValid <= w_cmdValidNxt;
            r_cmdError <= w_cmdErrorNxt;
        end
    end

    // Argument decode for the latched opcode against the current byte.
    always_comb begin
        w_argLegal = 1'b0;
        w_argDec   = 2'd0;
        case (r_op)
            OP_D: begin
                case (r_rxByte)
                    "P":     begin w_argLegal = 1'b1; w_argDec = c_DC_PROCEED;    end
                    "L":     begin w_argLegal = 1'b1; w_argDec = c_DC_TURN_LEFT;  end
                    "R":     begin w_argLegal = 1'b1; w_argDec = c_DC_TURN_RIGHT; end
                    "S":     begin w_argLegal = 1'b1; w_argDec = c_DC_STOP;       end
                    default: ;
                endcase
            end
            OP_F: begin
                case (r_rxByte)
                    "F":     begin w_argLegal = 1'b1; w_argDec = {1'b0, c_FORWARDS}; end
                    "R":     begin w_argLegal = 1'b1; w_argDec = {1'b0, c_REVERSE};  end
                    default: ;
                endcase
            end
            OP_M: begin
                case (r_rxByte)
                    "0":     begin w_argLegal = 1'b1; w_argDec = 2'd0; end
                    "1":     begin w_argLegal = 1'b1; w_argDec = 2'd1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        w_cStateNxt   = r_cState;
        w_opNxt       = r_op;
        w_argNxt      = r_arg;
        w_dirNxt      = r_dir;
        w_driveNxt    = r_drive;
        w_ovrNxt      = r_ovr;
        w_cmdValidNxt = 1'b0;
        w_cmdErrorNxt = 1'b0;
        if (r_frameErr) begin
            w_cStateNxt = C_DISCARD;
        end else if (r_rxValid && (r_rxByte != c_LF)) begin
            unique case (r_cState)
                C_CMD: begin
                    if (r_rxByte == "D") begin
                        w_opNxt = OP_D; w_cStateNxt = C_ARG;
                    end else if (r_rxByte == "F") begin
                        w_opNxt = OP_F; w_cStateNxt = C_ARG;
                    end else if (r_rxByte == "M") begin
                        w_opNxt = OP_M; w_cStateNxt = C_ARG;
                    end else if (r_rxByte != c_CR) begin
                        w_cStateNxt = C_DISCARD;
                    end
                end
                C_ARG: begin
                    if (r_rxByte == c_CR) begin
                        w_cmdErrorNxt = 1'b1;
                        w_cStateNxt   = C_CMD;
                    end else if (w_argLegal) begin
                        w_argNxt    = w_argDec;
                        w_cStateNxt = C_TERM;
                    end else begin
                        w_cStateNxt = C_DISCARD;
                    end
                end
                C_TERM: begin
                    if (r_rxByte == c_CR) begin
                        w_cmdValidNxt = 1'b1;
                        w_cStateNxt   = C_CMD;
                        case (r_op)
                            OP_D:    w_dirNxt   = r_arg;
                            OP_F:    w_driveNxt = r_arg[0];
                            OP_M:    w_ovrNxt   = r_arg[0];
                            default: ;
                        endcase
                    end else begin
                        w_cStateNxt = C_DISCARD;
                    end
                end
                C_DISCARD: begin
                    if (r_rxByte == c_CR) begin
                        w_cmdErrorNxt = 1'b1;
                        w_cStateNxt   = C_CMD;
                    end
                end
                default: w_cStateNxt = C_CMD;
            endcase
        end
    end

    assign bus.rxByte     = r_rxByte;
    assign bus.rxValid    = r_rxValid;
    assign bus.frameErr   = r_frameErr;
    assign bus.dirCmd     = r_dir;
    assign bus.driveCmd   = r_drive;
    assign bus.overrideEn = r_ovr;
    assign bus.cmdValid   = r_cmdValid;
    assign bus.cmdError   = r_cmdError;

endmodule
`default_nettype wire
